// File: rtl/grey_frame_streamer.sv
// Streams one raster-order frame from a synchronous-read pixel memory as vld/busy words.
// Optional 1-pixel zero border when GREY_PAD_EN is defined.
module grey_frame_streamer #(
  parameter int IMG_W  = 256,
  parameter int IMG_H  = 256,
  parameter int ADDR_W = 16,
  parameter int DATA_W = 24
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_start,
  output logic              o_active,
  output logic              o_done,
  output logic              o_mem_rd_en,
  output logic [ADDR_W-1:0] o_mem_addr,
  input  logic [DATA_W-1:0] i_mem_rd_data,
  output logic              o_grey_vld,
  output logic [DATA_W-1:0] o_grey_data,
  input  logic              i_grey_busy
);

`ifdef GREY_PAD_EN
  localparam int COLS = IMG_W + 2;
  localparam int ROWS = IMG_H + 2;
`else
  localparam int COLS = IMG_W;
  localparam int ROWS = IMG_H;
`endif
  localparam int CW = $clog2(COLS);
  localparam int RW = $clog2(ROWS);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t              state_q, state_d;
  logic [CW-1:0]       col_q, col_d;
  logic [RW-1:0]       row_q, row_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [1:0]          cnt_q, cnt_d;
  logic                infl_q;
  logic [DATA_W-1:0]   head_q, head_d;
  logic [DATA_W-1:0]   tail_q, tail_d;
  logic                issue, pop, push, last_slot, border;
  logic [DATA_W-1:0]   push_data;
`ifdef GREY_PAD_EN
  logic                zero_q;
`endif

  always_comb begin
    pop       = (cnt_q != 2'd0) && !i_grey_busy;
    push      = infl_q;
    // A slot is free if the word popped this cycle makes room for it.
    issue     = (state_q == S_RUN) &&
                (({1'b0, cnt_q} + {2'b0, infl_q}) < (3'd2 + {2'b0, pop}));
    last_slot = (row_q == RW'(ROWS - 1)) && (col_q == CW'(COLS - 1));
`ifdef GREY_PAD_EN
    border    = (row_q == '0) || (row_q == RW'(ROWS - 1)) ||
                (col_q == '0) || (col_q == CW'(COLS - 1));
    push_data = zero_q ? '0 : i_mem_rd_data;
`else
    border    = 1'b0;
    push_data = i_mem_rd_data;
`endif
    o_mem_rd_en = issue && !border;
    o_mem_addr  = addr_q;
    o_grey_vld  = (cnt_q != 2'd0);
    o_grey_data = head_q;
    o_active    = (state_q == S_RUN) || (state_q == S_DRAIN);
    o_done      = (state_q == S_DONE);
  end

  // Skid FIFO: head is the output register, tail only fills under backpressure.
  always_comb begin
    head_d = head_q;
    tail_d = tail_q;
    cnt_d  = cnt_q + {1'b0, push} - {1'b0, pop};
    case (cnt_q)
      2'd0: if (push) head_d = push_data;
      2'd1: begin
        if (push && pop) head_d = push_data;
        else if (push)   tail_d = push_data;
      end
      default: begin
        if (pop) begin
          head_d = tail_q;
          if (push) tail_d = push_data;
        end
      end
    endcase
  end

  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    row_d   = row_q;
    addr_d  = addr_q;
    if (o_mem_rd_en) addr_d = addr_q + ADDR_W'(1);
    if (issue) begin
      if (col_q == CW'(COLS - 1)) begin
        col_d = '0;
        row_d = last_slot ? '0 : row_q + RW'(1);
      end else begin
        col_d = col_q + CW'(1);
      end
    end
    case (state_q)
      S_IDLE: if (i_start) begin
        state_d = S_RUN;
        col_d   = '0;
        row_d   = '0;
        addr_d  = '0;
      end
      S_RUN:   if (issue && last_slot) state_d = S_DRAIN;
      S_DRAIN: if ((cnt_d == 2'd0) && !infl_q) state_d = S_DONE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= S_IDLE;
      col_q   <= '0;
      row_q   <= '0;
      addr_q  <= '0;
      cnt_q   <= 2'd0;
      infl_q  <= 1'b0;
      head_q  <= '0;
`ifdef GREY_PAD_EN
      zero_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      row_q   <= row_d;
      addr_q  <= addr_d;
      cnt_q   <= cnt_d;
      infl_q  <= issue;
      head_q  <= head_d;
`ifdef GREY_PAD_EN
      zero_q  <= issue && border;
`endif
    end
  end

  always_ff @(posedge i_clk) begin
    tail_q <= tail_d;
  end

endmodule

// File: tb/tb_grey_frame_streamer.sv
// Scoreboard bench for grey_frame_streamer (IMG_W=4, IMG_H=3, memory word k = 24'h0A0000+k).
module tb_grey_frame_streamer;
  localparam int W  = 4;
  localparam int H  = 3;
  localparam int AW = 16;
  localparam int DW = 24;
`ifdef GREY_PAD_EN
  localparam int NW = (W + 2) * (H + 2);
`else
  localparam int NW = W * H;
`endif

  logic          clk = 1'b0;
  logic          rst, start, busy;
  logic          active, done, rd_en, vld;
  logic [AW-1:0] addr;
  logic [DW-1:0] rd_data = '0;
  logic [DW-1:0] data;

  grey_frame_streamer #(.IMG_W(W), .IMG_H(H), .ADDR_W(AW), .DATA_W(DW)) dut (
    .i_clk(clk), .i_rst(rst), .i_start(start), .o_active(active), .o_done(done),
    .o_mem_rd_en(rd_en), .o_mem_addr(addr), .i_mem_rd_data(rd_data),
    .o_grey_vld(vld), .o_grey_data(data), .i_grey_busy(busy));

  always #5 clk = ~clk;

  always @(posedge clk) if (rd_en) rd_data <= 24'h0A0000 + {8'h00, addr};

  int errors = 0, checks = 0;
  int pcnt = 0, t0 = 0;
  int busy_mode = 0;
  int first_vld, act_first, act_cnt, done_rel, done_cnt = 0;
  int rd_idx = 0, out_q = 0;
  logic stall_q = 1'b0;
  logic [DW-1:0] held = '0;
  logic [DW-1:0] sb[$];

  always @(posedge clk) pcnt <= pcnt + 1;

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic void push_frame();
    for (int k = 0; k < NW; k++) begin
`ifdef GREY_PAD_EN
      int r, c;
      r = k / (W + 2);
      c = k % (W + 2);
      if (r == 0 || r == H + 1 || c == 0 || c == W + 1) sb.push_back('0);
      else sb.push_back(24'h0A0000 + DW'((r - 1) * W + (c - 1)));
`else
      sb.push_back(24'h0A0000 + DW'(k));
`endif
    end
  endfunction

  initial begin
    void'($urandom(1));
    busy = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (busy_mode)
        1:       busy = ((pcnt - t0) >= 4) && ((pcnt - t0) <= 9);
        2:       busy = 1'($urandom_range(0, 1));
        default: busy = 1'b0;
      endcase
    end
  end

  // Monitor: pops the scoreboard on every transfer and checks protocol rules.
  always @(negedge clk) begin
    automatic int  rel  = pcnt - t0;
    automatic logic xfer = vld && !busy;
    if (rst) begin
      sb.delete();
      out_q   = 0;
      rd_idx  = 0;
      stall_q = 1'b0;
    end else begin
      if (stall_q) begin
        check("hold_vld", vld, 1);
        check("hold_data", data, held);
      end
      if (xfer) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL extra_word: got %0h expected no word", data);
        end else begin
          check("word_data", data, sb.pop_front());
        end
      end
      if (rd_en) begin
        check("rd_addr", addr, rd_idx);
`ifndef GREY_PAD_EN
        check("no_overflow", ((out_q - int'(xfer)) < 2), 1);
`endif
        rd_idx++;
      end
      out_q = out_q + int'(rd_en) - int'(xfer);
      if (vld && first_vld < 0) first_vld = rel;
      if (active) begin
        act_cnt++;
        if (act_first < 0) act_first = rel;
      end
      if (done) begin
        done_cnt++;
        done_rel = rel;
        check("frame_drained", sb.size(), 0);
        check("reads_per_frame", rd_idx, W * H);
        rd_idx = 0;
      end
      stall_q = vld && busy;
      held    = data;
    end
  end

  task automatic start_frame();
    @(posedge clk);
    #1;
    start     = 1'b1;
    t0        = pcnt;
    first_vld = -1;
    act_first = -1;
    act_cnt   = 0;
    done_rel  = -1;
    push_frame();
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_done();
    int n;
    for (n = 0; n < 5000; n++) begin
      @(negedge clk);
      if (done) break;
    end
    if (n == 5000) begin
      checks++;
      errors++;
      $display("FAIL done_timeout: got no o_done expected one within 5000 cycles");
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_active"}, active, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_rd_en"}, rd_en, 0);
    check({tag, "_addr"}, addr, 0);
    check({tag, "_vld"}, vld, 0);
    check({tag, "_data"}, data, 0);
  endtask

  initial begin
    int d;
    rst   = 1'b1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_idle_outputs("reset");
    rst = 1'b0;

    // Free-running frame: latency and frame length.
    busy_mode = 0;
    d = done_cnt;
    start_frame();
    wait_done();
    @(posedge clk);
    #1;
    check("t1_first_vld_cycle", first_vld, 3);
    check("t1_done_cycle", done_rel, NW + 3);
    check("t1_active_first", act_first, 1);
    check("t1_active_cycles", act_cnt, NW + 2);
    check("t1_done_count", done_cnt, d + 1);
    check("t1_active_after", active, 0);

    // Backpressure window in cycles 4..9.
    busy_mode = 1;
    d = done_cnt;
    start_frame();
    wait_done();
    @(posedge clk);
    #1;
    check("t2_done_count", done_cnt, d + 1);
    busy_mode = 0;

    // Start ignored mid-frame; next start right after o_done.
    d = done_cnt;
    start_frame();
    repeat (4) @(posedge clk);
    #1;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_done();
    start_frame();
    wait_done();
    @(posedge clk);
    #1;
    check("t4_done_count", done_cnt, d + 2);
    check("t4_back2back_first_vld", first_vld, 3);

    // Random backpressure over 20 frames.
    busy_mode = 2;
    for (int f = 0; f < 20; f++) begin
      d = done_cnt;
      start_frame();
      wait_done();
      @(posedge clk);
      #1;
      check("t3_done_per_frame", done_cnt, d + 1);
    end
    busy_mode = 0;

    // Reset in cycle 7 aborts the frame without o_done.
    start_frame();
    repeat (6) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check_idle_outputs("midreset");
    d = done_cnt;
    repeat (20) @(posedge clk);
    #1;
    check("t5_no_done_after_abort", done_cnt, d);
    start_frame();
    wait_done();
    @(posedge clk);
    #1;
    check("t5_restart_done", done_cnt, d + 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
